// File: rtl/uart_autobaud_if.sv
// Bus between the auto-baud controller and its neighbours: rx pin synchronizer,
// register block (start/cancel/status) and baud generator (cfg_div/baud_clear).
interface uart_autobaud_if #(
  parameter int CNT_W = 20
);
  logic             rx;
  logic             start;
  logic             cancel;
  logic [15:0]      cfg_div;
  logic             baud_clear;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] meas_cnt;

  modport slave (
    input  rx, start, cancel,
    output cfg_div, baud_clear, busy, done, err, meas_cnt
  );

  modport master (
    output rx, start, cancel,
    input  cfg_div, baud_clear, busy, done, err, meas_cnt
  );
endinterface

// File: rtl/uart_autobaud.sv
// Auto-baud controller: times five falling edges of a 0x55 sync character and
// derives cfg_div. Define UART_AUTOBAUD_ROUND_EN to round the divider to nearest.
module uart_autobaud #(
  parameter logic [15:0] DEFAULT_DIV = 16'd433,
  parameter int          CNT_W       = 20,
  parameter int          MIN_CNT     = 128
) (
  input  logic          clk,
  input  logic          rst,
  uart_autobaud_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_FALL,
    MEASURE,
    CALC
  } state_t;

  state_t           state;
  logic             rx_q;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       edge_cnt;
  logic [15:0]      cfg_div;
  logic [CNT_W-1:0] meas_cnt;
  logic             baud_clear;
  logic             done;
  logic             err;

  // N spans 8 bit-times, so the bit period is N/8 clocks and the divider one less.
  function automatic logic [15:0] calc_div(input logic [CNT_W-1:0] n);
    logic [31:0] t;
`ifdef UART_AUTOBAUD_ROUND_EN
    t = 32'(n) + 32'd4;
`else
    t = 32'(n);
`endif
    t = (t >> 3) - 32'd1;
    return t[15:0];
  endfunction

  function automatic logic too_short(input logic [CNT_W-1:0] n);
    return (n < CNT_W'(MIN_CNT));
  endfunction

  assign fall = rx_q & ~bus.rx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_q       <= 1'b1;
      cnt        <= '0;
      edge_cnt   <= '0;
      cfg_div    <= DEFAULT_DIV;
      meas_cnt   <= '0;
      baud_clear <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rx_q       <= bus.rx;
      baud_clear <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      if (bus.cancel) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) state <= ARM;
          end
          ARM: begin
            if (rx_q) state <= WAIT_FALL;
          end
          WAIT_FALL: begin
            if (fall) begin
              cnt      <= CNT_W'(1);
              edge_cnt <= 3'd1;
              state    <= MEASURE;
            end
          end
          MEASURE: begin
            if (cnt == '1) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
              if (fall) begin
                if (edge_cnt == 3'd4) begin
                  // Result is registered on entry so the pulses and new divider
                  // are presented during the CALC cycle itself.
                  state <= CALC;
                  if (too_short(cnt)) begin
                    err <= 1'b1;
                  end else begin
                    cfg_div    <= calc_div(cnt);
                    meas_cnt   <= cnt;
                    baud_clear <= 1'b1;
                    done       <= 1'b1;
                  end
                end else begin
                  edge_cnt <= edge_cnt + 3'd1;
                end
              end
            end
          end
          CALC: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.cfg_div    = cfg_div;
  assign bus.meas_cnt   = meas_cnt;
  assign bus.baud_clear = baud_clear;
  assign bus.done       = done;
  assign bus.err        = err;

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud; CNT_W is shrunk to 14 so the counter
// saturation case completes in a short run.
module tb_uart_autobaud;
  localparam int CNT_W = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_autobaud_if #(.CNT_W(CNT_W)) bus ();

  uart_autobaud #(
    .DEFAULT_DIV (16'd433),
    .CNT_W       (CNT_W),
    .MIN_CNT     (128)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  int done_n = 0, bc_n = 0, err_n = 0;
  int done_cyc = -1, bc_cyc = -1, err_cyc = -1;
  logic prev_done = 1'b0;
  logic busy_after = 1'b1;
  int n_chk = 0, n_pass = 0;
  int fall1_cyc, fall5_cyc;
  int d0, b0, e0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
    if (bus.baud_clear) begin
      bc_n   <= bc_n + 1;
      bc_cyc <= cyc;
    end
    if (bus.err) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
    end
    if (prev_done) busy_after <= bus.busy;
    prev_done <= bus.done;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic snap();
    d0 = done_n;
    b0 = bc_n;
    e0 = err_n;
  endtask

  // 0x55 framed LSB first; falls at bits 0,2,4,6,8. extra7 stretches bit 7.
  task automatic send_frame(input int bl, input int extra7);
    logic [9:0] bits;
    bits = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = bits[i];
      if (i == 0) fall1_cyc = cyc;
      if (i == 8) fall5_cyc = cyc;
      tick(bl + ((i == 7) ? extra7 : 0));
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.rx     = 1'b1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    chk("reset_cfg_div", 32'(bus.cfg_div), 32'd433);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_meas_cnt", 32'(bus.meas_cnt), 32'd0);
    chk("reset_pulses", 32'({bus.done, bus.err, bus.baud_clear}), 32'd0);

    // rx activity without start must not do anything
    snap();
    for (int i = 0; i < 10; i++) begin
      bus.rx = ~bus.rx;
      tick(5);
    end
    bus.rx = 1'b1;
    tick(5);
    chk("idle_no_pulses", 32'((done_n - d0) + (bc_n - b0) + (err_n - e0)), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // 115200 baud at 50 MHz
    snap();
    pulse_start();
    tick(3);
    send_frame(434, 0);
    tick(20);
    chk("b115_cfg_div", 32'(bus.cfg_div), 32'd433);
    chk("b115_meas_cnt", 32'(bus.meas_cnt), 32'd3472);
    chk("b115_done_cnt", 32'(done_n - d0), 32'd1);
    chk("b115_bc_cnt", 32'(bc_n - b0), 32'd1);
    chk("b115_err_cnt", 32'(err_n - e0), 32'd0);
    chk("b115_done_lat", 32'(done_cyc), 32'(fall5_cyc + 1));
    chk("b115_bc_lat", 32'(bc_cyc), 32'(fall5_cyc + 1));
    chk("b115_busy_after", 32'(busy_after), 32'd0);

    // line low at start: ARM must wait for idle before taking an edge
    bus.rx = 1'b0;
    tick(5);
    snap();
    pulse_start();
    tick(20);
    chk("arm_busy", 32'(bus.busy), 32'd1);
    bus.rx = 1'b1;
    tick(10);
    send_frame(100, 0);
    tick(20);
    chk("arm_cfg_div", 32'(bus.cfg_div), 32'd99);
    chk("arm_meas_cnt", 32'(bus.meas_cnt), 32'd800);
    chk("arm_done_cnt", 32'(done_n - d0), 32'd1);

    // too fast: N=120 below MIN_CNT
    snap();
    pulse_start();
    tick(3);
    send_frame(15, 0);
    tick(20);
    chk("short_err_cnt", 32'(err_n - e0), 32'd1);
    chk("short_err_lat", 32'(err_cyc), 32'(fall5_cyc + 1));
    chk("short_bc_cnt", 32'(bc_n - b0), 32'd0);
    chk("short_done_cnt", 32'(done_n - d0), 32'd0);
    chk("short_cfg_div", 32'(bus.cfg_div), 32'd99);
    chk("short_meas_cnt", 32'(bus.meas_cnt), 32'd800);

    // single edge then stuck low: counter saturates at 2^CNT_W-1
    snap();
    pulse_start();
    tick(3);
    bus.rx = 1'b0;
    fall1_cyc = cyc;
    for (int i = 0; i < 17000; i++) begin
      if (err_n != e0) break;
      tick(1);
    end
    chk("ovf_err_cnt", 32'(err_n - e0), 32'd1);
    chk("ovf_err_lat", 32'(err_cyc), 32'(fall1_cyc + (1 << CNT_W)));
    chk("ovf_busy", 32'(bus.busy), 32'd0);
    chk("ovf_bc_cnt", 32'(bc_n - b0), 32'd0);
    chk("ovf_cfg_div", 32'(bus.cfg_div), 32'd99);
    bus.rx = 1'b1;
    tick(5);

    // cancel after two falling edges
    snap();
    pulse_start();
    tick(3);
    bus.rx = 1'b0;
    tick(50);
    bus.rx = 1'b1;
    tick(50);
    bus.rx = 1'b0;
    tick(20);
    chk("cancel_busy_before", 32'(bus.busy), 32'd1);
    bus.cancel = 1'b1;
    tick(1);
    bus.cancel = 1'b0;
    chk("cancel_busy_next", 32'(bus.busy), 32'd0);
    tick(30);
    bus.rx = 1'b1;
    tick(10);
    chk("cancel_no_pulses", 32'((done_n - d0) + (bc_n - b0) + (err_n - e0)), 32'd0);
    chk("cancel_cfg_div", 32'(bus.cfg_div), 32'd99);

    // cancel beats start in IDLE
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    tick(1);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    chk("cancel_start_idle", 32'(bus.busy), 32'd0);

    // reset mid-measurement restores the default divider
    pulse_start();
    tick(3);
    bus.rx = 1'b0;
    tick(30);
    rst = 1'b1;
    bus.rx = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstmid_cfg_div", 32'(bus.cfg_div), 32'd433);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_meas_cnt", 32'(bus.meas_cnt), 32'd0);
    tick(3);

    // N=3476: rounding decides between 433 and 434
    snap();
    pulse_start();
    tick(3);
    send_frame(434, 4);
    tick(20);
    chk("round_meas_cnt", 32'(bus.meas_cnt), 32'd3476);
`ifdef UART_AUTOBAUD_ROUND_EN
    chk("round_cfg_div", 32'(bus.cfg_div), 32'd434);
`else
    chk("round_cfg_div", 32'(bus.cfg_div), 32'd433);
`endif
    chk("round_done_cnt", 32'(done_n - d0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
